// File: rtl/mcycle_ctrl.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// memory handshake timeout, stall freeze and a retired-instruction counter.
module mcycle_ctrl #(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 4,
  parameter int TO_CYC  = 15,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               stall,
  input  logic               mem_ready,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halted,
  output logic               mem_err,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5;

  localparam logic [3:0] OPC_NOP  = 4'h0, OPC_ADD  = 4'h1, OPC_SUB  = 4'h2,
                         OPC_AND  = 4'h3, OPC_OR   = 4'h4, OPC_XOR  = 4'h5,
                         OPC_SLT  = 4'h6, OPC_ADDI = 4'h7, OPC_ANDI = 4'h8,
                         OPC_ORI  = 4'h9, OPC_XORI = 4'hA, OPC_LW   = 4'hB,
                         OPC_SW   = 4'hC, OPC_BEQ  = 4'hD, OPC_BNE  = 4'hE,
                         OPC_HALT = 4'hF;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0), ALU_SUB = ALUOP_W'(1),
                                 ALU_AND = ALUOP_W'(2), ALU_OR  = ALUOP_W'(3),
                                 ALU_XOR = ALUOP_W'(4), ALU_SLT = ALUOP_W'(5);

  // The wait counter only has to hold values up to TO_CYC-1.
  localparam int WC_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TO_CYC - 1);

  logic [2:0]       state_reg, state_next;
  logic             run_reg;
  logic [OP_W-1:0]  op_reg;
  logic [3:0]       op_dec;
  logic [WC_W-1:0]  wait_reg;
  logic             ready_seen_reg;
  logic             mem_err_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             advance, ready_eff, timeout, is_ld, is_st;

  generate
    if (OP_W > 4) begin : g_wide_op
      assign op_dec = (op_reg[OP_W-1:4] == '0) ? op_reg[3:0] : OPC_NOP;
    end else begin : g_narrow_op
      assign op_dec = op_reg[3:0];
    end
  endgenerate

  // run_reg holds the FSM idle until the first edge after reset release.
  assign advance   = run_reg && !stall;
  assign ready_eff = mem_ready || ready_seen_reg;
  assign is_ld     = (op_dec == OPC_LW);
  assign is_st     = (op_dec == OPC_SW);
  assign timeout   = (state_reg == S_MEM) && !ready_eff && (wait_reg == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (advance) begin
      case (state_reg)
        S_FETCH:  state_next = S_DECODE;
        S_DECODE: state_next = S_EXEC;
        S_EXEC: begin
          case (op_dec)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SLT,
            OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI: state_next = S_WB;
            OPC_LW, OPC_SW:                        state_next = S_MEM;
            OPC_HALT:                              state_next = S_HALT;
            default:                               state_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (ready_eff)    state_next = is_ld ? S_WB : S_FETCH;
          else if (timeout) state_next = S_HALT;
        end
        S_WB:    state_next = S_FETCH;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    case (state_reg)
      S_FETCH: ir_load = advance;
      S_EXEC: begin
        case (op_dec)
          OPC_SUB, OPC_BEQ, OPC_BNE: alu_op = ALU_SUB;
          OPC_AND, OPC_ANDI:         alu_op = ALU_AND;
          OPC_OR,  OPC_ORI:          alu_op = ALU_OR;
          OPC_XOR, OPC_XORI:         alu_op = ALU_XOR;
          OPC_SLT:                   alu_op = ALU_SLT;
          default:                   alu_op = ALU_ADD;
        endcase
        alu_src = (op_dec == OPC_ADDI) || (op_dec == OPC_ANDI) || (op_dec == OPC_ORI) ||
                  (op_dec == OPC_XORI) || is_ld || is_st;
        if ((op_dec == OPC_BEQ) || (op_dec == OPC_BNE)) begin
          pc_write = advance;
          pc_src   = ((op_dec == OPC_BEQ) && zero) || ((op_dec == OPC_BNE) && !zero);
        end
      end
      S_MEM: begin
        // The request survives stall; only completion strobes are gated.
        mem_read  = is_ld;
        mem_write = is_st;
        pc_write  = is_st && ready_eff && advance;
      end
      S_WB: begin
        reg_write  = advance;
        mem_to_reg = is_ld;
        pc_write   = advance;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg         <= '0;
      wait_reg       <= '0;
      ready_seen_reg <= 1'b0;
      mem_err_reg    <= 1'b0;
      retired_reg    <= '0;
    end else begin
      if (advance && (state_reg == S_DECODE)) op_reg <= opcode;
      if (advance) begin
        if ((state_reg != S_MEM) && (state_next == S_MEM)) wait_reg <= '0;
        else if ((state_reg == S_MEM) && !ready_eff)      wait_reg <= wait_reg + 1'b1;
      end
      // A ready seen under stall is kept until the first unstalled MEM cycle.
      if ((state_reg == S_MEM) && stall && mem_ready) ready_seen_reg <= 1'b1;
      else if (!stall)                                ready_seen_reg <= 1'b0;
      if (advance && timeout) mem_err_reg <= 1'b1;
      if ((state_next == S_FETCH) &&
          ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB)))
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign halted  = (state_reg == S_HALT);
  assign mem_err = mem_err_reg;
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: cycle-vector table, hand-written corner
// sequences, and a random instruction stream checked per instruction.
module tb_mcycle_ctrl;
  localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_LW = 11, OP_SW = 12,
                 OP_BEQ = 13, OP_BNE = 14, OP_HALT = 15;
  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_SLT = 5;
  localparam int NPROG = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = '0;
  logic        zero = 1'b0, stall = 1'b0, mem_ready = 1'b0;
  logic        ir_load, pc_write, pc_src, reg_write, alu_src;
  logic        mem_read, mem_write, mem_to_reg, halted, mem_err;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;
  logic [7:0]  flags;
  logic [32:0] all_out;

  assign flags   = {ir_load, pc_write, pc_src, reg_write, alu_src, mem_read, mem_write, mem_to_reg};
  assign all_out = {flags, alu_op, halted, mem_err, state, retired};

  mcycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .stall(stall),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .halted(halted), .mem_err(mem_err),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        z, st, rdy;
    logic [2:0]  est;
    logic [7:0]  efl;
    logic [3:0]  ealu;
    logic [15:0] eret;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int op, input bit z, input bit st, input bit rdy,
                     input int est, input logic [7:0] efl, input int ealu, input int eret);
    vec_t v;
    v.op = 4'(op); v.z = z; v.st = st; v.rdy = rdy;
    v.est = 3'(est); v.efl = efl; v.ealu = 4'(ealu); v.eret = 16'(eret);
    tbl.push_back(v);
  endtask

  // Reset is asynchronous and must hold everything at zero across clock edges.
  task automatic do_reset(input int tag);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    #1 chk("rst_async_outputs", tag, all_out, 0);
    @(posedge clk); #1 chk("rst_held_outputs", tag, all_out, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_release_no_fetch", tag, ir_load, 0);
  endtask

  function automatic int exp_alu(input int op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return A_SUB;
      3, 8:                   return A_AND;
      4, 9:                   return A_OR;
      5, 10:                  return A_XOR;
      6:                      return A_SLT;
      default:                return A_ADD;
    endcase
  endfunction

  function automatic int exp_src(input int op);
    return (op >= 7 && op <= 12) ? 1 : 0;
  endfunction

  int prog_op[NPROG+1], prog_z[NPROG+1], prog_lat[NPROG+1];
  int cur, act, pw, ps, rw, m2r, memc, cap_alu, cap_src;

  // Reference: cost and strobe counts of one instruction from its class.
  task automatic close_instr(input int k);
    int op, e_cyc, e_pw, e_ps, e_rw, e_m2r, e_mem;
    op = prog_op[k];
    e_cyc = 3; e_pw = 1; e_ps = 0; e_rw = 0; e_m2r = 0; e_mem = 0;
    if (op >= 1 && op <= 10) begin
      e_cyc = 4; e_rw = 1;
    end else if (op == OP_LW) begin
      e_mem = prog_lat[k] + 1; e_cyc = 3 + e_mem + 1; e_rw = 1; e_m2r = 1;
    end else if (op == OP_SW) begin
      e_mem = prog_lat[k] + 1; e_cyc = 3 + e_mem;
    end else if (op == OP_BEQ) begin
      e_ps = prog_z[k];
    end else if (op == OP_BNE) begin
      e_ps = 1 - prog_z[k];
    end else begin
      e_pw = 0;
    end
    chk("rand_cycles", k, act, e_cyc);
    chk("rand_pc_write", k, pw, e_pw);
    chk("rand_pc_src", k, ps, e_ps);
    chk("rand_reg_write", k, rw, e_rw);
    chk("rand_mem_to_reg", k, m2r, e_m2r);
    chk("rand_mem_cycles", k, memc, e_mem);
    chk("rand_alu_op", k, cap_alu, exp_alu(op));
    chk("rand_alu_src", k, cap_src, exp_src(op));
  endtask

  initial begin
    int n, halt_cnt, cyc_cnt;
    bit done;

    do_reset(0);

    // ADD, LW with 3 wait cycles, BEQ/BNE with zero=1, SUB stalled in DECODE,
    // SW whose ready arrives under stall.
    add(OP_ADD,0,0,0, 0,8'h80,A_ADD,0); add(OP_ADD,0,0,0, 1,8'h00,A_ADD,0);
    add(OP_ADD,0,0,0, 2,8'h00,A_ADD,0); add(OP_ADD,0,0,0, 4,8'h50,A_ADD,0);
    add(OP_LW,0,0,0, 0,8'h80,A_ADD,1);  add(OP_LW,0,0,0, 1,8'h00,A_ADD,1);
    add(OP_LW,0,0,0, 2,8'h08,A_ADD,1);  add(OP_LW,0,0,0, 3,8'h04,A_ADD,1);
    add(OP_LW,0,0,0, 3,8'h04,A_ADD,1);  add(OP_LW,0,0,0, 3,8'h04,A_ADD,1);
    add(OP_LW,0,0,1, 3,8'h04,A_ADD,1);  add(OP_LW,0,0,0, 4,8'h51,A_ADD,1);
    add(OP_BEQ,1,0,0, 0,8'h80,A_ADD,2); add(OP_BEQ,1,0,0, 1,8'h00,A_ADD,2);
    add(OP_BEQ,1,0,0, 2,8'h60,A_SUB,2); add(OP_BNE,1,0,0, 0,8'h80,A_ADD,3);
    add(OP_BNE,1,0,0, 1,8'h00,A_ADD,3); add(OP_BNE,1,0,0, 2,8'h40,A_SUB,3);
    add(OP_SUB,0,0,0, 0,8'h80,A_ADD,4); add(OP_SUB,0,1,0, 1,8'h00,A_ADD,4);
    add(OP_SUB,0,1,0, 1,8'h00,A_ADD,4); add(OP_SUB,0,0,0, 1,8'h00,A_ADD,4);
    add(OP_SUB,0,0,0, 2,8'h00,A_SUB,4); add(OP_SUB,0,0,0, 4,8'h50,A_ADD,4);
    add(OP_SW,0,0,0, 0,8'h80,A_ADD,5);  add(OP_SW,0,0,0, 1,8'h00,A_ADD,5);
    add(OP_SW,0,0,0, 2,8'h08,A_ADD,5);  add(OP_SW,0,1,1, 3,8'h02,A_ADD,5);
    add(OP_SW,0,1,0, 3,8'h02,A_ADD,5);  add(OP_SW,0,0,0, 3,8'h42,A_ADD,5);
    add(OP_SW,0,0,0, 0,8'h80,A_ADD,6);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      opcode = tbl[i].op; zero = tbl[i].z; stall = tbl[i].st; mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_state", i, state, tbl[i].est);
      chk("tbl_flags", i, flags, tbl[i].efl);
      chk("tbl_alu_op", i, alu_op, tbl[i].ealu);
      chk("tbl_retired", i, retired, tbl[i].eret);
    end

    // SW that never sees mem_ready: 15 request cycles, then HALT with mem_err.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == 3'd5) break;
      @(posedge clk); #1;
      @(negedge clk);
      if (mem_write) n++;
    end
    chk("to_req_cycles", 0, n, 15);
    chk("to_state", 0, state, 5);
    chk("to_mem_err", 0, mem_err, 1);
    chk("to_halted", 0, halted, 1);
    chk("to_retired", 0, retired, 6);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; stall = i[0];
      @(negedge clk);
      chk("to_halt_hold", i, {state, ir_load, pc_write, reg_write, mem_read, mem_write}, {3'd5, 5'd0});
    end

    // Reset mid-MEM drops the request before any clock edge.
    do_reset(1);
    opcode = 4'(OP_LW);
    for (int i = 0; i < 10 && !mem_read; i++) begin
      @(posedge clk); #1; @(negedge clk);
    end
    chk("mid_mem_req_seen", 2, mem_read, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_mem_async_drop", 2, {mem_read, state}, 0);
    @(posedge clk); #1 chk("mid_mem_held", 2, all_out, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("mid_mem_no_early_fetch", 2, ir_load, 0);
    @(posedge clk); #1 chk("mid_mem_first_fetch", 2, {ir_load, state}, {1'b1, 3'd0});

    // Random instruction stream with random stalls, ending in HALT.
    for (int k = 0; k < NPROG; k++) begin
      prog_op[k] = $urandom_range(0, 14);
      prog_z[k] = $urandom_range(0, 1);
      prog_lat[k] = $urandom_range(0, 6);
    end
    prog_op[NPROG] = OP_HALT; prog_z[NPROG] = 0; prog_lat[NPROG] = 0;
    do_reset(3);
    cur = -1; done = 0; halt_cnt = 0; cyc_cnt = 0;
    act = 0; pw = 0; ps = 0; rw = 0; m2r = 0; memc = 0; cap_alu = 0; cap_src = 0;
    while (!done && cyc_cnt < 4000) begin
      @(posedge clk); #1; cyc_cnt++;
      stall = ($urandom_range(0, 4) == 0);
      mem_ready = 1'b0;
      #1;
      if (ir_load) begin
        if (cur >= 0) close_instr(cur);
        cur++;
        chk("rand_retired", cur, retired, cur);
        opcode = 4'(prog_op[cur]); zero = prog_z[cur][0];
        act = 0; pw = 0; ps = 0; rw = 0; m2r = 0; memc = 0; cap_alu = 0; cap_src = 0;
      end
      if (cur >= 0 && (mem_read || mem_write) && !stall && memc == prog_lat[cur]) mem_ready = 1'b1;
      @(negedge clk);
      if (stall) begin
        chk("rand_stall_strobes", cur, {ir_load, pc_write, reg_write}, 0);
      end else begin
        act++;
        pw += int'(pc_write);
        ps += int'(pc_write && pc_src);
        rw += int'(reg_write);
        m2r += int'(reg_write && mem_to_reg);
        if (mem_read || mem_write) memc++;
        if (state == 3'd2) begin cap_alu = int'(alu_op); cap_src = int'(alu_src); end
      end
      if (cur == NPROG && state == 3'd5) begin
        halt_cnt++;
        chk("halt_hold", halt_cnt, {halted, state, ir_load, pc_write, reg_write, mem_read, mem_write},
            {1'b1, 3'd5, 5'd0});
        if (halt_cnt == 10) done = 1;
      end
    end
    chk("rand_finished", cur, done, 1);
    chk("rand_final_retired", cur, retired, NPROG);
    chk("rand_no_mem_err", cur, mem_err, 0);
    do_reset(4);
    @(posedge clk); #1 chk("after_halt_reset", 4, {state, retired, halted}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
